// File: rtl/lc_en_filter.sv
// rtl/lc_en_filter.sv - Qualifies a synchronized lc_tx_t enable into a filtered, drainable, error-latching enable.
// Optional build macro LC_EN_FILTER_DRAIN_TIMEOUT_EN bounds the time spent waiting for idle_i in DRAIN.
module lc_en_filter #(
    parameter int unsigned FilterCycles = 4,
    parameter int unsigned DrainTimeout = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] lc_en_i,
    input  logic       idle_i,
    input  logic       clr_err_i,
    output logic       en_o,
    output logic [3:0] lc_en_o,
    output logic       stop_req_o,
    output logic       err_o
);

    localparam logic [3:0] LcOn       = 4'b1010;
    localparam logic [3:0] LcOff      = 4'b0101;
    localparam logic [7:0] FilterLast = 8'(FilterCycles - 1);

    generate
        if (FilterCycles < 1 || FilterCycles > 255) begin : g_bad_filter
            $error("lc_en_filter: FilterCycles must be within 1..255");
        end
        if (DrainTimeout < 1 || DrainTimeout > 255) begin : g_bad_timeout
            $error("lc_en_filter: DrainTimeout must be within 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        StOff,
        StArm,
        StOn,
        StDrain,
        StError
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_on, is_off, is_invalid;
    logic       drain_expired;

    assign is_on      = (lc_en_i == LcOn);
    assign is_off     = (lc_en_i == LcOff);
    assign is_invalid = !is_on && !is_off;

`ifdef LC_EN_FILTER_DRAIN_TIMEOUT_EN
    localparam logic [7:0] DrainLimit = 8'(DrainTimeout);
    logic [7:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] drain_inc;

    assign drain_inc     = drain_cnt_q + 8'd1;
    assign drain_expired = (state_q == StDrain) && (drain_inc == DrainLimit);

    // Counts edges spent in DRAIN; zero on the entry edge and everywhere else.
    always_comb begin
        drain_cnt_d = 8'd0;
        if (state_q == StDrain && state_d == StDrain) begin
            drain_cnt_d = drain_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt_q <= 8'd0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end
`else
    assign drain_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = is_on ? ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1) : 8'd0;

        unique case (state_q)
            StOff: begin
                if (is_invalid) begin
                    state_d = StError;
                end else if (is_on) begin
                    state_d = (FilterCycles == 1) ? StOn : StArm;
                    cnt_d   = 8'd1;
                end
            end
            StArm: begin
                if (is_invalid) begin
                    state_d = StError;
                end else if (is_on) begin
                    if (cnt_q == FilterLast) begin
                        state_d = StOn;
                    end
                end else begin
                    state_d = StOff;
                end
            end
            StOn: begin
                if (is_invalid) begin
                    state_d = StError;
                end else if (is_off) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // On samples here are deliberately ignored; only idle_i leaves DRAIN cleanly.
                if (is_invalid) begin
                    state_d = StError;
                end else if (idle_i) begin
                    state_d = StOff;
                end else if (drain_expired) begin
                    state_d = StError;
                end
            end
            StError: begin
                if (clr_err_i && is_off) begin
                    state_d = StOff;
                end
            end
            default: state_d = StError;
        endcase

        if (state_d == StOff) begin
            cnt_d = 8'd0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            cnt_q      <= 8'd0;
            en_o       <= 1'b0;
            lc_en_o    <= LcOff;
            stop_req_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_o       <= (state_d == StOn);
            lc_en_o    <= (state_d == StOn) ? LcOn : LcOff;
            stop_req_o <= (state_d == StDrain);
            err_o      <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_lc_en_filter.sv
// tb/tb_lc_en_filter.sv - Scoreboard bench for lc_en_filter with directed vectors.
module tb_lc_en_filter;

    localparam logic [3:0] ON  = 4'b1010;
    localparam logic [3:0] OFF = 4'b0101;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] lc_en_i = OFF;
    logic       idle_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic       en_o;
    logic [3:0] lc_en_o;
    logic       stop_req_o;
    logic       err_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic [3:0] lc;
        logic       stop;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    lc_en_filter #(.FilterCycles(4), .DrainTimeout(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .lc_en_i    (lc_en_i),
        .idle_i     (idle_i),
        .clr_err_i  (clr_err_i),
        .en_o       (en_o),
        .lc_en_o    (lc_en_o),
        .stop_req_o (stop_req_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input logic r, input logic [3:0] lc, input logic idle, input logic clr,
                        input logic e_en, input logic e_stop, input logic e_err, input string nm);
        exp_t e;
        @(negedge clk_i);
        rst_i     = r;
        lc_en_i   = lc;
        idle_i    = idle;
        clr_err_i = clr;
        e.en   = e_en;
        e.lc   = e_en ? ON : OFF;
        e.stop = e_stop;
        e.err  = e_err;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic arm_to_on(input string nm);
        for (int i = 0; i < 4; i++) step(0, ON, 0, 0, (i == 3), 0, 0, nm);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({en_o, lc_en_o, stop_req_o, err_o} !== {e.en, e.lc, e.stop, e.err}) begin
                failures++;
                $display("FAIL %s: got en=%b lc=%b stop=%b err=%b, want en=%b lc=%b stop=%b err=%b",
                         e.name, en_o, lc_en_o, stop_req_o, err_o, e.en, e.lc, e.stop, e.err);
            end
        end
    end

    initial begin
        step(1, OFF, 0, 0, 0, 0, 0, "reset");
        step(1, ON,  0, 0, 0, 0, 0, "reset_on_in");

        arm_to_on("arm");
        step(0, ON, 0, 0, 1, 0, 0, "on_hold");

        for (int i = 0; i < 5; i++) step(0, OFF, 0, 0, 0, 1, 0, "drain_wait");
        step(0, OFF, 1, 0, 0, 0, 0, "drain_idle");

        for (int i = 0; i < 3; i++) step(0, ON, 0, 0, 0, 0, 0, "filt_pre");
        step(0, OFF, 0, 0, 0, 0, 0, "filt_break");
        for (int i = 0; i < 4; i++) step(0, ON, 0, 0, (i == 3), 0, 0, "filt_rearm");

        step(0, OFF, 0, 0, 0, 1, 0, "drain_enter");
        step(0, ON,  0, 0, 0, 1, 0, "drain_on_ignored");
        step(0, ON,  1, 0, 0, 0, 0, "drain_idle_on");
        step(0, OFF, 0, 1, 0, 0, 0, "clr_outside_err");

        step(0, ON,    0, 0, 0, 0, 0, "inv_arm");
        step(0, 4'hF,  0, 0, 0, 0, 1, "inv_enter");
        step(0, ON,    0, 0, 0, 0, 1, "err_sticky");
        step(0, ON,    0, 1, 0, 0, 1, "clr_with_on");
        step(0, 4'h0,  0, 1, 0, 0, 1, "clr_with_inv");
        step(0, OFF,   0, 1, 0, 0, 0, "clr_with_off");

        arm_to_on("arm2");
        step(0, OFF,  0, 0, 0, 1, 0, "drain2");
        step(0, 4'h0, 1, 0, 0, 0, 1, "idle_and_inv");
        step(0, OFF,  0, 1, 0, 0, 0, "clr2");

        arm_to_on("arm3");
        step(1, ON, 0, 0, 0, 0, 0, "rst_in_on");
        arm_to_on("rearm_after_rst");
        step(0, 4'hC, 0, 0, 0, 0, 1, "inv_in_on");
        step(1, ON,   0, 0, 0, 0, 0, "rst_in_err");
        step(0, ON,   0, 0, 0, 0, 0, "post_rst_arm");
        step(0, OFF,  0, 0, 0, 0, 0, "post_rst_off");

        arm_to_on("arm4");
        step(0, OFF, 0, 0, 0, 1, 0, "drain_long_enter");
`ifdef LC_EN_FILTER_DRAIN_TIMEOUT_EN
        for (int i = 1; i < 16; i++) step(0, OFF, 0, 0, 0, 1, 0, "to_wait");
        step(0, OFF, 0, 0, 0, 0, 1, "to_expire");
        step(0, OFF, 0, 1, 0, 0, 0, "to_clr");
        arm_to_on("arm5");
        step(0, OFF, 0, 0, 0, 1, 0, "to2_enter");
        for (int i = 1; i < 16; i++) step(0, OFF, 0, 0, 0, 1, 0, "to2_wait");
        step(0, OFF, 1, 0, 0, 0, 0, "to2_idle_wins");
`else
        for (int i = 0; i < 20; i++) step(0, OFF, 0, 0, 0, 1, 0, "drain_no_timeout");
        step(0, OFF, 1, 0, 0, 0, 0, "drain_long_idle");
`endif

        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
